// File: rtl/normal_word_feeder.sv
// ---------------------------------------------------------------------------
// normal_word_feeder
//
// Streams the dense ("normal") polynomial into the round datapath one word
// at a time. Each run sends NORMAL_WORD_COUNT words read from a synchronous
// word memory, then FLUSH_WORDS zero words. The first PRELOAD_WORDS words are
// flagged add-only. Completion is reported with a one-cycle run_done pulse.
//
// Per word the sequence is READ -> LOAD -> SEND -> WAIT for memory words and
// SEND -> WAIT for flush words. Every output is a register that follows the
// state register one cycle later. So start sampled at edge N gives mem_rd_en
// at N+1 and word_valid at N+3.
//
// Optional feature (compile-time macro NORMAL_WORD_FEEDER_TIMEOUT_EN):
//   A watchdog counts WAIT cycles. If TIMEOUT_CYCLES pass without
//   processing_done, it sets the sticky timeout_err flag and ends the run.
//   When the macro is undefined, WAIT waits indefinitely and timeout_err is
//   tied to 0.
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-high reset
//   start           in   run request, sampled in IDLE only
//   base_addr       in   first memory address, captured with start
//   mem_rd_en       out  memory read strobe (one cycle per memory word)
//   mem_addr        out  read address, base + index modulo 2^ADDR_WIDTH
//   mem_rdata       in   read data, valid one cycle after mem_rd_en
//   normal_word_in  out  word offered to the datapath
//   word_valid      out  one-cycle offer pulse
//   only_add        out  current word only fills the queue
//   word_accepted   in   datapath captured the word
//   processing_done in   datapath finished with the word
//   busy            out  run in progress (through the run_done cycle)
//   run_done        out  one-cycle pulse after the last word completes
//   word_index      out  0-based index of the word in flight
//   timeout_err     out  sticky watchdog flag
// ---------------------------------------------------------------------------
module normal_word_feeder #(
  parameter int WORD_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 10,
  parameter int NORMAL_WORD_COUNT = 553,
  parameter int PRELOAD_WORDS     = 1,
  parameter int FLUSH_WORDS       = 19,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic [WORD_WIDTH-1:0] normal_word_in,
  output logic                  word_valid,
  output logic                  only_add,
  input  logic                  word_accepted,
  input  logic                  processing_done,
  output logic                  busy,
  output logic                  run_done,
  output logic [9:0]            word_index,
  output logic                  timeout_err
);

  // Index thresholds expressed at the width of the word counter.
  localparam logic [9:0] MEM_WORDS_C   = 10'(NORMAL_WORD_COUNT);
  localparam logic [9:0] PRELOAD_C     = 10'(PRELOAD_WORDS);
  localparam logic [9:0] TOTAL_WORDS_C = 10'(NORMAL_WORD_COUNT + FLUSH_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_WAIT = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Sequencer state
  state_t                  state_r;
  state_t                  state_s;
  logic [9:0]              idx_r;
  logic [9:0]              idx_s;
  logic [9:0]              idx_inc_s;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic                    accepted_r;
  logic                    flush_s;
  logic                    wait_timeout_s;

  // Output registers
  logic                    mem_rd_en_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic [WORD_WIDTH-1:0]   word_r;
  logic                    word_valid_r;
  logic                    only_add_r;
  logic                    busy_r;
  logic                    run_done_r;

  assign mem_rd_en      = mem_rd_en_r;
  assign mem_addr       = mem_addr_r;
  assign normal_word_in = word_r;
  assign word_valid     = word_valid_r;
  assign only_add       = only_add_r;
  assign busy           = busy_r;
  assign run_done       = run_done_r;
  assign word_index     = idx_r;

  // Words at or past the memory count are zero flush words and bypass memory.
  assign flush_s = (idx_r >= MEM_WORDS_C);

`ifdef NORMAL_WORD_FEEDER_TIMEOUT_EN
  // The counter must hold the value TIMEOUT_CYCLES-1.
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST_C = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE_C  = TMO_W'(1);

  logic [TMO_W-1:0] wait_cnt_r;
  logic             tmo_hit_r;
  logic             timeout_err_r;

  // The last allowed WAIT cycle passes with no processing_done.
  assign wait_timeout_s = (state_r == ST_WAIT) && !processing_done &&
                          (wait_cnt_r == TMO_LAST_C);
  assign timeout_err    = timeout_err_r;

  // Watchdog: count unanswered WAIT cycles and remember an expiry.
  // tmo_hit_r delays the visible flag by one cycle. This lines it up with
  // run_done, which also trails the DONE state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r    <= '0;
      tmo_hit_r     <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      if ((state_r == ST_WAIT) && !processing_done && !wait_timeout_s) begin
        wait_cnt_r <= wait_cnt_r + TMO_ONE_C;
      end else begin
        wait_cnt_r <= '0;
      end
      if (wait_timeout_s) begin
        tmo_hit_r <= 1'b1;
      end else begin
        tmo_hit_r <= tmo_hit_r;
      end
      timeout_err_r <= timeout_err_r | tmo_hit_r;
    end
  end

  // Nothing downstream consumes the accept record; it is kept for debug.
  logic unused_s;
  assign unused_s = accepted_r;
`else
  assign wait_timeout_s = 1'b0;
  assign timeout_err    = 1'b0;

  // Without the watchdog the timeout parameter and the accept record have
  // no consumer.
  logic [32:0] unused_s;
  assign unused_s = {accepted_r, 32'(TIMEOUT_CYCLES)};
`endif

  // Next-state and next-index logic for the word sequencer.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    idx_inc_s = idx_r + 10'd1;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_READ;
          idx_s   = 10'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: state_s = ST_LOAD;
      ST_LOAD: state_s = ST_SEND;
      ST_SEND: state_s = ST_WAIT;
      ST_WAIT: begin
        // processing_done alone advances the word. A preceding
        // word_accepted is not required.
        if (processing_done) begin
          idx_s = idx_inc_s;
          if (idx_inc_s == TOTAL_WORDS_C) begin
            state_s = ST_DONE;
          end else if (idx_inc_s < MEM_WORDS_C) begin
            state_s = ST_READ;
          end else begin
            state_s = ST_SEND;
          end
        end else if (wait_timeout_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, word index, captured base address and accept record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= 10'd0;
      base_r     <= '0;
      accepted_r <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      if ((state_r == ST_IDLE) && start) begin
        base_r <= base_addr;
      end else begin
        base_r <= base_r;
      end
      // The accept record is cleared per word and set by any accept seen
      // while waiting.
      if (state_r == ST_SEND) begin
        accepted_r <= 1'b0;
      end else if ((state_r == ST_WAIT) && word_accepted) begin
        accepted_r <= 1'b1;
      end else begin
        accepted_r <= accepted_r;
      end
    end
  end

  // Output registers derived from the current state, one cycle behind it.
  // The read strobed in READ returns data while the state register holds
  // SEND. The word register therefore samples mem_rdata on the edge that
  // leaves SEND, the same edge that raises word_valid. word and only_add
  // then hold unchanged through WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_en_r  <= 1'b0;
      mem_addr_r   <= '0;
      word_r       <= '0;
      word_valid_r <= 1'b0;
      only_add_r   <= 1'b0;
      busy_r       <= 1'b0;
      run_done_r   <= 1'b0;
    end else begin
      mem_rd_en_r  <= (state_r == ST_READ);
      word_valid_r <= (state_r == ST_SEND);
      busy_r       <= (state_r != ST_IDLE);
      run_done_r   <= (state_r == ST_DONE);
      if (state_r == ST_READ) begin
        // Address arithmetic wraps modulo 2^ADDR_WIDTH.
        mem_addr_r <= base_r + ADDR_WIDTH'(idx_r);
      end else begin
        mem_addr_r <= mem_addr_r;
      end
      if (state_r == ST_SEND) begin
        word_r     <= flush_s ? '0 : mem_rdata;
        only_add_r <= (idx_r < PRELOAD_C);
      end else begin
        word_r     <= word_r;
        only_add_r <= only_add_r;
      end
    end
  end

endmodule

// File: tb/tb_normal_word_feeder.sv
module tb_normal_word_feeder;
  localparam int WW    = 32;
  localparam int AW    = 10;
  localparam int NWC   = 4;
  localparam int PRE   = 2;
  localparam int FL    = 2;
  localparam int TMO   = 8;
  localparam int TOTAL = NWC + FL;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_rdata;
  logic [WW-1:0] normal_word_in;
  logic          word_valid;
  logic          only_add;
  logic          word_accepted;
  logic          processing_done;
  logic          busy;
  logic          run_done;
  logic [9:0]    word_index;
  logic          timeout_err;

  normal_word_feeder #(
    .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .NORMAL_WORD_COUNT(NWC),
    .PRELOAD_WORDS(PRE), .FLUSH_WORDS(FL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .normal_word_in(normal_word_in), .word_valid(word_valid), .only_add(only_add),
    .word_accepted(word_accepted), .processing_done(processing_done),
    .busy(busy), .run_done(run_done), .word_index(word_index),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: data one cycle after the strobe, garbage otherwise.
  logic [WW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    else           mem_rdata <= $urandom;
  end

  int checks = 0;
  int bad    = 0;

  function automatic void chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail(input string nm, input string why);
    checks++;
    bad++;
    $display("FAIL %s: %s (cycle %0d)", nm, why, cyc);
  endfunction

  // Scoreboard queues
  typedef struct { logic [WW-1:0] data; bit add; int idx; int abs_cyc; int gap; } word_exp_t;
  typedef struct { int addr; int abs_cyc; } addr_exp_t;
  word_exp_t wq[$];
  addr_exp_t aq[$];
  int        rq[$];
  int        runs_issued = 0;
  int        runs_seen   = 0;

  // Responder configuration
  int rmode     = 0;
  int fix_add   = 2;
  int fix_proc  = 3;
  int fix_acc   = 1;
  int never_idx = -1;

  // Datapath responder: counts negedges after the word_valid it saw.
  initial begin : responder
    bit active;
    int k, acc_k, pd_k;
    active = 0; k = 0; acc_k = 0; pd_k = 0;
    word_accepted   = 1'b0;
    processing_done = 1'b0;
    forever begin
      @(negedge clk);
      word_accepted   = 1'b0;
      processing_done = 1'b0;
      if (rst || !busy) begin
        active = 0;
      end else if (active) begin
        k++;
        if (k == acc_k) word_accepted = 1'b1;
        if (k == pd_k) begin
          processing_done = 1'b1;
          active = 0;
        end
      end else if (word_valid) begin
        active = 1; k = 0;
        if (rmode == 0) begin
          pd_k  = only_add ? fix_add : fix_proc;
          acc_k = fix_acc;
        end else begin
          pd_k  = $urandom_range(1, 5);
          acc_k = $urandom_range(0, pd_k + 1);
        end
        if (int'(word_index) == never_idx) pd_k = 1 << 30;
        if (acc_k == 0) word_accepted = 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents something.
  initial begin : monitor
    bit            in_flight;
    bit            busy_drop;
    logic [WW-1:0] held_w;
    logic          held_a;
    int            last_wv, pd_cnt;
    word_exp_t     we;
    addr_exp_t     ae;
    in_flight = 0; busy_drop = 0; held_w = '0; held_a = 1'b0; last_wv = 0; pd_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        in_flight = 0; busy_drop = 0; pd_cnt = 0;
      end else begin
        if (busy_drop) begin
          chk("busy_after_done", busy, 0);
          busy_drop = 0;
        end
        if (mem_rd_en) begin
          if (aq.size() == 0) begin
            fail("unexpected_read", $sformatf("got read of 0x%0h want no read", mem_addr));
          end else begin
            ae = aq.pop_front();
            chk("mem_addr", mem_addr, ae.addr);
            if (ae.abs_cyc >= 0) chk("rd_en_latency", cyc, ae.abs_cyc);
          end
        end
        if (word_valid) begin
          if (in_flight) fail("word_valid_repeat", "got word_valid want none before processing_done");
          if (wq.size() == 0) begin
            fail("unexpected_word", $sformatf("got word 0x%0h want none", normal_word_in));
          end else begin
            we = wq.pop_front();
            chk("word_data", normal_word_in, we.data);
            chk("only_add", only_add, we.add);
            chk("word_index", word_index, we.idx);
            if (we.abs_cyc >= 0) chk("first_valid_latency", cyc, we.abs_cyc);
            if (we.gap >= 0) chk("valid_spacing", cyc - last_wv, we.gap);
          end
          in_flight = 1; held_w = normal_word_in; held_a = only_add; last_wv = cyc;
        end else if (in_flight) begin
          chk("word_stable", normal_word_in, held_w);
          chk("only_add_stable", only_add, held_a);
          if (processing_done) begin
            in_flight = 0;
            pd_cnt++;
          end
        end
        if (run_done) begin
          if (rq.size() == 0) fail("unexpected_run_done", "got run_done want none");
          else chk("done_count", pd_cnt, rq.pop_front());
          chk("busy_at_done", busy, 1);
          in_flight = 0; pd_cnt = 0; busy_drop = 1;
          runs_seen++;
        end
      end
    end
  end

  // Issue one run: reference model pushes every expected word and read.
  task automatic run(input logic [AW-1:0] base, input bit timed, input int exp_pd);
    word_exp_t we;
    addr_exp_t ae;
    int c;
    @(negedge clk);
    c = cyc;
    for (int i = 0; i < TOTAL; i++) begin
      we.data    = (i < NWC) ? mem[(int'(base) + i) % 1024] : '0;
      we.add     = (i < PRE);
      we.idx     = i;
      we.abs_cyc = (timed && i == 0) ? c + 4 : -1;
      we.gap     = (timed && i > 0) ? (((i < NWC) ? 6 : 4) + (((i - 1) < PRE) ? 0 : 1)) : -1;
      wq.push_back(we);
      if (i < NWC) begin
        ae.addr    = (int'(base) + i) % 1024;
        ae.abs_cyc = (timed && i == 0) ? c + 2 : -1;
        aq.push_back(ae);
      end
    end
    rq.push_back(exp_pd);
    runs_issued++;
    start = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
    base_addr = AW'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wq.delete(); aq.delete(); rq.delete();
    @(negedge clk);
    @(negedge clk);
    runs_issued = runs_seen;
    rst = 1'b0;
  endtask

  // Bounded wait for all issued runs; optionally pokes start while busy.
  task automatic wait_done(input string nm, input bit poke);
    int n;
    n = 0;
    while (runs_seen < runs_issued && n < 400) begin
      @(negedge clk);
      n++;
      if (poke && busy && !run_done && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        base_addr = AW'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (runs_seen < runs_issued) begin
      fail(nm, "got no run_done within 400 cycles want run_done");
      do_reset();
    end else begin
      repeat (12) @(negedge clk);
      chk({nm, "_words_left"}, wq.size(), 0);
      chk({nm, "_reads_left"}, aq.size(), 0);
      chk({nm, "_timeout_err"}, timeout_err, 0);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_mem_rd_en"}, mem_rd_en, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_word"}, normal_word_in, 0);
    chk({nm, "_word_valid"}, word_valid, 0);
    chk({nm, "_only_add"}, only_add, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_run_done"}, run_done, 0);
    chk({nm, "_word_index"}, word_index, 0);
    chk({nm, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin : stim
    bit found;
    int t0;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Fixed 2/3-cycle responder: data, flags and cycle spacing.
    rmode = 0; fix_add = 2; fix_proc = 3; fix_acc = 1;
    run(10'h020, 1'b1, TOTAL);
    wait_done("run_basic", 1'b0);

    // Address wrap with random responder timing.
    rmode = 1;
    run(10'h3FE, 1'b0, TOTAL);
    wait_done("run_wrap", 1'b0);

    // Slow datapath: done 10 cycles after accept.
    rmode = 0; fix_add = 11; fix_proc = 11; fix_acc = 1;
    run(AW'($urandom), 1'b0, TOTAL);
    wait_done("run_slow", 1'b0);

    // start pulses while busy must be ignored.
    rmode = 1;
    run(AW'($urandom), 1'b0, TOTAL);
    wait_done("run_poke", 1'b1);

    // Asynchronous reset in the middle of word 2.
    run(AW'($urandom), 1'b0, TOTAL);
    found = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (word_valid && word_index == 10'd2) found = 1;
    end
    if (!found) fail("reset_point", "got no word_valid for word 2 want one");
    #1 rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    wq.delete(); aq.delete(); rq.delete();
    @(negedge clk);
    @(negedge clk);
    runs_issued = runs_seen;
    rst = 1'b0;
    run(10'h010, 1'b0, TOTAL);
    wait_done("run_after_reset", 1'b0);

    // A few more random runs.
    for (int r = 0; r < 3; r++) begin
      run(AW'($urandom), 1'b0, TOTAL);
      wait_done("run_rand", 1'b0);
    end

`ifdef NORMAL_WORD_FEEDER_TIMEOUT_EN
    // Responder never answers word 1.
    rmode = 0; fix_add = 2; fix_proc = 3; fix_acc = 1; never_idx = 1;
    run(AW'($urandom), 1'b0, 1);
    found = 0; t0 = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (word_valid && word_index == 10'd1) begin found = 1; t0 = cyc; end
    end
    if (!found) fail("tmo_word1", "got no word_valid for word 1 want one");
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (timeout_err) found = 1;
    end
    if (!found) begin
      fail("tmo_flag", "got timeout_err=0 want 1");
    end else begin
      chk("tmo_latency", cyc - t0, 9);
      chk("tmo_run_done", run_done, 1);
      @(negedge clk);
      chk("tmo_busy", busy, 0);
      chk("tmo_sticky", timeout_err, 1);
    end
    never_idx = -1;
    wq.delete(); aq.delete();
    do_reset();
    #1 chk("tmo_cleared", timeout_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule

// File: doc/normal_word_feeder.md
# normal_word_feeder

Sequencer that streams the normal (dense) polynomial, one word at a time, from a synchronous word memory into the round datapath over the `word_valid` / `word_accepted` / `processing_done` handshake. It is the transmitter for that interface and sits between the polynomial RAM and the round datapath. Per run it sends a preload burst flagged add-only, the remaining body words, and zero flush words, then reports completion.

## Interface
Parameters:
- `WORD_WIDTH`, 32, word width
- `ADDR_WIDTH`, 10, memory address width
- `NORMAL_WORD_COUNT`, 553, words read from memory per run
- `PRELOAD_WORDS`, 1, leading words sent with `only_add`=1 (1..`NORMAL_WORD_COUNT`)
- `FLUSH_WORDS`, 19, zero words appended after the memory words
- `TIMEOUT_CYCLES`, 64, watchdog limit (only with `NORMAL_WORD_FEEDER_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  run request, sampled in IDLE only
- `base_addr`  in  `ADDR_WIDTH`  first memory address, captured on accepted `start`
- `mem_rd_en`  out  1  memory read strobe
- `mem_addr`  out  `ADDR_WIDTH`  read address
- `mem_rdata`  in  `WORD_WIDTH`  read data, valid exactly 1 cycle after `mem_rd_en`
- `normal_word_in`  out  `WORD_WIDTH`  word to datapath
- `word_valid`  out  1  one-cycle word-offer pulse
- `only_add`  out  1  current word is queue-fill only
- `word_accepted`  in  1  datapath captured the word
- `processing_done`  in  1  datapath finished with the word
- `busy`  out  1  run in progress
- `run_done`  out  1  one-cycle pulse after the last word completes
- `word_index`  out  10  index of the word in flight (0-based)
- `timeout_err`  out  1  sticky watchdog flag (tied 0 without the macro)

## Operation
- States: IDLE, READ, LOAD, SEND, WAIT, DONE.
- IDLE: `busy`=0. On `start`: latch `base_addr`, clear `word_index`, go READ.
- READ: `mem_rd_en`=1 for one cycle, `mem_addr`=base+`word_index`, modulo 2^`ADDR_WIDTH` (wraps, no error). Go LOAD.
- LOAD: register `mem_rdata` into `normal_word_in`. Go SEND.
- Flush words (`word_index` ≥ `NORMAL_WORD_COUNT`) skip READ/LOAD. `normal_word_in` is set to 0 on entry to SEND.
- SEND: `word_valid`=1 for exactly one cycle. `only_add`=1 iff `word_index` < `PRELOAD_WORDS`. Go WAIT.
- WAIT: hold `normal_word_in` and `only_add` stable until `processing_done`=1.
  - `word_accepted` alone is recorded but does not advance.
  - `processing_done` without a prior or simultaneous `word_accepted` is still honored.
  - Then increment `word_index`. If the new index equals `NORMAL_WORD_COUNT`+`FLUSH_WORDS`, go DONE. Otherwise go READ (memory word) or SEND (flush word).
- DONE: `run_done`=1 for one cycle, go IDLE.
- `start` outside IDLE is ignored.
- `word_valid` is never reasserted before `processing_done` for the current word.
- `rst` asserted mid-run aborts immediately. No partial `run_done`; a new `start` is required.

## Timing
- Reset values:
  - state IDLE; `mem_rd_en`, `word_valid`, `only_add`, `busy`, `run_done`, `timeout_err` = 0
  - `mem_addr`, `normal_word_in`, `word_index` = 0
- All outputs are registered.
- `start` at edge N: `mem_rd_en` at N+1, `word_valid` at N+3.
- Per memory word: 3 cycles plus the datapath wait. Per flush word: 1 cycle plus the wait.
- With a datapath answering `processing_done` 2 cycles after `word_valid` (add-only) or 3 cycles (processing), consecutive `word_valid` pulses are spaced 6/7 cycles for memory words and 4/5 cycles for flush words.
- `busy`=1 from the cycle after the accepted `start` through the `run_done` cycle.

## Configuration
- `NORMAL_WORD_FEEDER_TIMEOUT_EN` defined:
  - A counter runs in WAIT. If `TIMEOUT_CYCLES` elapse without `processing_done`, set `timeout_err` (sticky until `rst`) and go DONE.
  - `run_done` still pulses.
- Macro undefined: no counter, WAIT waits indefinitely, `timeout_err` tied 0.

## Test plan
Bench parameters: `NORMAL_WORD_COUNT`=4, `PRELOAD_WORDS`=2, `FLUSH_WORDS`=2.
- Reset during SEND of word 2 -> next cycle all outputs at reset values. A later `start` with `base_addr`=0x10 produces `mem_addr`=0x10 first.
- Memory 0x20..0x23 = A,B,C,D, `base_addr`=0x20, responder model -> `word_valid` carries A,B,C,D,0,0. `only_add`=1 for A,B only. Exactly one `run_done`, after the 6th `processing_done`.
- `base_addr`=0x3FE (`ADDR_WIDTH`=10) -> reads 0x3FE, 0x3FF, 0x000, 0x001.
- Responder delays `processing_done` by 10 cycles after `word_accepted` -> one `word_valid` per word, `normal_word_in` stable throughout WAIT.
- `start` pulsed while `busy` -> ignored. `word_index` sequence unchanged; a single `run_done`.
- With the macro, `TIMEOUT_CYCLES`=8, responder never answers word 1 -> `timeout_err`=1 nine cycles after its `word_valid`, then `run_done`, `busy`=0.
